// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL phase sequencer.
//   state_e            - sequencer FSM states
//   CNT_SEL_*          - altpll phasecounterselect encodings
//   DEFAULT_TIMEOUT    - clk cycles allowed for phasedone / pll_locked
//   step_phase()       - one saturating phase step up or down
package pll_seq_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      START       = 3'd1,
      SWITCH      = 3'd2,
      WAIT_LOCK   = 3'd3,
      STEP_SETUP  = 3'd4,
      STEP_ASSERT = 3'd5,
      STEP_WAIT   = 3'd6,
      DONE        = 3'd7
   } state_e;

   localparam logic [2:0] CNT_SEL_ALL = 3'b000;
   localparam logic [2:0] CNT_SEL_M   = 3'b001;
   localparam logic [2:0] CNT_SEL_C0  = 3'b010;
   localparam logic [2:0] CNT_SEL_C1  = 3'b011;
   localparam logic [2:0] CNT_SEL_C2  = 3'b100;
   localparam logic [2:0] CNT_SEL_C3  = 3'b101;
   localparam logic [2:0] CNT_SEL_C4  = 3'b110;

   localparam int DEFAULT_TIMEOUT = 1023;

   // Applied phase after one step; clamps at 0 and 255 instead of wrapping.
   function automatic logic [7:0] step_phase(input logic [7:0] cur, input logic up);
      logic [7:0] res;
      if (up) begin
         res = (cur == 8'hFF) ? cur : cur + 8'd1;
      end else begin
         res = (cur == 8'h00) ? cur : cur - 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pll_phase_sequencer_scanclk_gen.sv
// scanclk_gen: divided scan clock with enable.
//   clk, reset_n - system clock, async active-low reset
//   en           - count while high (divider running this cycle)
//   clr          - force scanclk low and restart the divider on the next edge
//   scanclk      - registered scan clock, clk/(2*DIV), starts low
//   rise, fall   - one-cycle strobes, high in the clk cycle whose edge makes
//                  scanclk rise / fall
module scanclk_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic scanclk,
   output logic rise,
   output logic fall
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          tick_s;

   // Divider next state; clr is kept out of the strobes so the sequencer can
   // derive clr from its own next state without a combinational loop.
   always_comb begin
      tick_s = en && (cnt_q == CW'(DIV - 1));
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (clr || !en) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (tick_s) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         cnt_d  = cnt_q + CW'(1);
      end
   end

   // Divider registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign scanclk = sclk_q;
   assign rise    = tick_s && !sclk_q;
   assign fall    = tick_s &&  sclk_q;

endmodule

// File: rtl/pll_phase_sequencer.sv
// pll_phase_sequencer: walks the altpll from its applied source/phase to the
// host target using clkswitch and dynamic phase-shift handshakes.
//   inputs : clk, reset_n, updatepll (request strobe), pll_clk_src,
//            pll_clk_phase (targets), phasedone, pll_locked (from altpll)
//   outputs: phasecounterselect, phaseupdown, phasestep, scanclk, clkswitch
//            (to altpll), busy, cur_phase, cur_src, error (status)
module pll_phase_sequencer
   import pll_seq_pkg::*;
#(
   parameter int         SCANCLK_DIV = 4,
   parameter logic [2:0] CNT_SEL     = CNT_SEL_ALL,
   parameter int         SWITCH_HOLD = 8,
   parameter int         TIMEOUT     = DEFAULT_TIMEOUT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       updatepll,
   input  logic       pll_clk_src,
   input  logic [7:0] pll_clk_phase,
   input  logic       phasedone,
   input  logic       pll_locked,
   output logic [2:0] phasecounterselect,
   output logic       phaseupdown,
   output logic       phasestep,
   output logic       scanclk,
   output logic       clkswitch,
   output logic       busy,
   output logic [7:0] cur_phase,
   output logic       cur_src,
   output logic       error
);

   localparam int CMAX = (TIMEOUT > SWITCH_HOLD) ? TIMEOUT : SWITCH_HOLD;
   localparam int CW   = $clog2(CMAX + 1);

   state_e        state_q, state_d;
   logic          pending_q, pending_d;
   logic          tgt_src_q, tgt_src_d;
   logic [7:0]    tgt_phase_q, tgt_phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    edge_q, edge_d;
   logic          low_seen_q, low_seen_d;
   logic [7:0]    cur_phase_q, cur_phase_d;
   logic          cur_src_q, cur_src_d;
   logic          error_q, error_d;
   logic          busy_q, busy_d;
   logic          phasestep_q, phasestep_d;
   logic          clkswitch_q, clkswitch_d;
   logic          updown_q, updown_d;
   logic [2:0]    cntsel_q, cntsel_d;
   logic [7:0]    next_phase_s;
   logic          sc_en_s, sc_clr_s, sc_rise_s, sc_fall_s;

   // The scan clock only runs in the working states and is forced low on the
   // edge that enters DONE or IDLE.
   assign sc_en_s  = (state_q != IDLE) && (state_q != DONE);
   assign sc_clr_s = (state_d == IDLE) || (state_d == DONE);

   scanclk_gen #(.DIV(SCANCLK_DIV)) u_scanclk (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (sc_en_s),
      .clr     (sc_clr_s),
      .scanclk (scanclk),
      .rise    (sc_rise_s),
      .fall    (sc_fall_s)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      tgt_src_d    = tgt_src_q;
      tgt_phase_d  = tgt_phase_q;
      cnt_d        = cnt_q;
      edge_d       = edge_q;
      low_seen_d   = low_seen_q;
      cur_phase_d  = cur_phase_q;
      cur_src_d    = cur_src_q;
      error_d      = error_q;
      updown_d     = updown_q;
      next_phase_s = step_phase(cur_phase_q, updown_q);

      case (state_q)
         IDLE: begin
            if (updatepll || pending_q) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            tgt_src_d   = pll_clk_src;
            tgt_phase_d = pll_clk_phase;
            pending_d   = 1'b0;
            error_d     = 1'b0;
            if (pll_clk_src != cur_src_q) begin
               state_d = SWITCH;
            end else if (pll_clk_phase != cur_phase_q) begin
               state_d = STEP_SETUP;
            end else begin
               state_d = DONE;
            end
         end
         SWITCH: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SWITCH_HOLD - 1)) begin
               state_d = WAIT_LOCK;
            end else begin
               state_d = SWITCH;
            end
         end
         WAIT_LOCK: begin
            cnt_d = cnt_q + CW'(1);
            if (pll_locked) begin
               cur_src_d = tgt_src_q;
               state_d   = (tgt_phase_q != cur_phase_q) ? STEP_SETUP : DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STEP_SETUP: begin
            // Direction settles on the first falling edge; the step starts on
            // the next one, a full scanclk period later.
            if (sc_fall_s) begin
               updown_d = (tgt_phase_q > cur_phase_q);
               if (edge_q == 2'd1) begin
                  state_d = STEP_ASSERT;
               end else begin
                  edge_d = edge_q + 2'd1;
               end
            end else begin
               state_d = STEP_SETUP;
            end
         end
         STEP_ASSERT: begin
            // edge_q counts scanclk rising edges seen with phasestep high.
            if (sc_rise_s && (edge_q != 2'd3)) begin
               edge_d = edge_q + 2'd1;
            end else if (sc_fall_s && (edge_q == 2'd2)) begin
               state_d = STEP_WAIT;
            end else begin
               state_d = STEP_ASSERT;
            end
         end
         STEP_WAIT: begin
            // Each phasedone edge gets its own timeout window.
            cnt_d = cnt_q + CW'(1);
            if (!low_seen_q) begin
               if (!phasedone) begin
                  low_seen_d = 1'b1;
                  cnt_d      = '0;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = STEP_WAIT;
               end
            end else begin
               if (phasedone) begin
                  cur_phase_d = next_phase_s;
                  state_d     = (next_phase_s == tgt_phase_q) ? DONE : STEP_SETUP;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  error_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = STEP_WAIT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe while busy (including the DONE->IDLE cycle) is held, and
      // wins over the clear done in START.
      if (updatepll && (state_q != IDLE)) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_d;
      end

      // Per-state counters restart on every state change.
      if (state_d != state_q) begin
         cnt_d      = '0;
         edge_d     = 2'd0;
         low_seen_d = 1'b0;
      end else begin
         low_seen_d = low_seen_d;
      end

      busy_d      = (state_d != IDLE);
      phasestep_d = (state_d == STEP_ASSERT);
      clkswitch_d = (state_d == SWITCH);
      cntsel_d    = (state_d != IDLE) ? CNT_SEL : 3'b000;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pending_q   <= 1'b0;
         tgt_src_q   <= 1'b0;
         tgt_phase_q <= 8'd0;
         cnt_q       <= '0;
         edge_q      <= 2'd0;
         low_seen_q  <= 1'b0;
         cur_phase_q <= 8'd0;
         cur_src_q   <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
         phasestep_q <= 1'b0;
         clkswitch_q <= 1'b0;
         updown_q    <= 1'b0;
         cntsel_q    <= 3'b000;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         tgt_src_q   <= tgt_src_d;
         tgt_phase_q <= tgt_phase_d;
         cnt_q       <= cnt_d;
         edge_q      <= edge_d;
         low_seen_q  <= low_seen_d;
         cur_phase_q <= cur_phase_d;
         cur_src_q   <= cur_src_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
         phasestep_q <= phasestep_d;
         clkswitch_q <= clkswitch_d;
         updown_q    <= updown_d;
         cntsel_q    <= cntsel_d;
      end
   end

   assign phasecounterselect = cntsel_q;
   assign phaseupdown        = updown_q;
   assign phasestep          = phasestep_q;
   assign clkswitch          = clkswitch_q;
   assign busy               = busy_q;
   assign cur_phase          = cur_phase_q;
   assign cur_src            = cur_src_q;
   assign error              = error_q;

endmodule

// File: doc/pll_phase_sequencer.md
Name: pll_phase_sequencer

Overview:
- Sequences PLL reconfiguration requested by the serial command processor. It consumes that block's `updatepll` strobe and its `pll_clk_src` / `pll_clk_phase` targets.
- It drives the Cyclone III altpll dynamic-phase-shift port (`phasecounterselect`, `phaseupdown`, `phasestep`, `scanclk`) and the `clkswitch` input.
- It tracks the applied phase and source, so a host command only states the target and the block performs the required step and switch handshakes.
- Sits between the processor and the altpll instance in the top level.

Parameters:
- SCANCLK_DIV, 4: clk cycles per scanclk half-period; scanclk = clk/(2*SCANCLK_DIV).
- CNT_SEL, 3'b000: phasecounterselect value (000 = all counters).
- SWITCH_HOLD, 8: clk cycles clkswitch is held high.
- TIMEOUT, 1023: clk cycles allowed for phasedone or pll_locked before abort.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- updatepll  in  1  one-cycle request strobe from the processor
- pll_clk_src  in  1  target input clock (0 = inclk0)
- pll_clk_phase  in  8  target phase, in PLL phase steps
- phasedone  in  1  altpll phasedone (low while a step is in progress)
- pll_locked  in  1  altpll locked
- phasecounterselect  out  3  driven to CNT_SEL whenever busy, 0 when idle
- phaseupdown  out  1  1 = up, 0 = down
- phasestep  out  1  step request
- scanclk  out  1  divided scan clock, toggles only while busy
- clkswitch  out  1  source-switch pulse
- busy  out  1  sequence in progress
- cur_phase  out  8  applied phase
- cur_src  out  1  applied source
- error  out  1  last sequence aborted on timeout

Behaviour:
- **Reset** (async, reset_n=0): every output is 0, including cur_phase=0 and cur_src=0. The pending flag is cleared and the FSM goes to IDLE. Reset mid-sequence abandons it immediately; the PLL is reset by the same net, so 0/0 matches hardware.
- **Request capture:**
  - An updatepll seen while busy sets pending (requests coalesce; only one is held).
  - The targets tgt_src and tgt_phase are sampled on entry to START, never mid-sequence.
- **IDLE:** if updatepll or pending, go to START. The cycle after updatepll, busy=1.
- **START:**
  - Latch the targets, clear pending, clear error.
  - If tgt_src != cur_src, go to SWITCH.
  - Else if tgt_phase != cur_phase, go to STEP_SETUP.
  - Else go to DONE (no-op, busy high for exactly 2 cycles).
- **SWITCH:** clkswitch=1 for SWITCH_HOLD cycles, then go to WAIT_LOCK.
- **WAIT_LOCK:**
  - Wait for pll_locked=1, then toggle cur_src and go on to the phase check as in START.
  - Timeout: error=1, go to DONE with cur_src unchanged.
- **Scan clock:** scanclk runs from a counter that is free while busy and starts low. Outputs change only on the clk cycle that produces a scanclk falling edge.
- **STEP_SETUP:**
  - phaseupdown = (tgt_phase > cur_phase), unsigned compare, no wrap.
  - phasecounterselect=CNT_SEL.
  - Wait one full scanclk period, then go to STEP_ASSERT.
- **STEP_ASSERT:** phasestep=1, held across 2 scanclk rising edges, deasserted on the following falling edge; then go to STEP_WAIT.
- **STEP_WAIT:**
  - Wait for phasedone low, then high.
  - On high: cur_phase ±1 (8-bit, saturating at 0/255); if cur_phase == tgt_phase go to DONE, else go to STEP_SETUP.
  - If either edge times out: error=1, go to DONE; cur_phase is not updated for the failed step.
- **DONE:** scanclk low, phasestep=0, clkswitch=0, busy=0, then go to IDLE. If pending, the next request starts one cycle later.
- **Ordering:** source switch always precedes phase stepping within a sequence.
- **Simultaneous events:** updatepll in the same cycle as DONE→IDLE is captured as pending; it is never lost.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (IDLE, START, SWITCH, WAIT_LOCK, STEP_SETUP, STEP_ASSERT, STEP_WAIT, DONE);
  - CNT_SEL encodings (ALL=000, M=001, C0=010 … C4=110);
  - the default timeout constant.
- One sub-module, scanclk_gen: a divider with enable that outputs scanclk plus one-cycle rise/fall strobes.

Test Plan:
- **Phase up:** from reset, updatepll with src=0, phase=3, phasedone model responding 20 clk after each step → exactly 3 phasestep pulses, phaseupdown=1, cur_phase=3, busy then low, error=0.
- **Phase down:** from cur_phase=3, request phase=1 → 2 steps with phaseupdown=0, cur_phase=1; each phasestep spans ≥2 scanclk rising edges.
- **Source switch:** request src=1, phase unchanged → clkswitch high exactly 8 clk; pll_locked rises 50 clk later → cur_src=1 and no phasestep.
- **No-op and reset request:** a request equal to the current state gives busy for 2 cycles and no outputs toggle. Request src=0, phase=0 from src=1, phase=2 → switch first, then 2 down steps.
- **Timeout:** phasedone held high → after TIMEOUT cycles error=1, cur_phase unchanged, busy=0. A following request clears error.
- **Coalescing and reset:** 3 updatepll strobes mid-sequence → exactly one extra sequence, using the targets at its START. reset_n low mid-STEP_ASSERT → all outputs 0 asynchronously, cur_phase=0.
